// File: rtl/instruction_encoder_loader_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction formats and the
// field bundle handed from the loader to the field packer. Also consumed by
// immediate_generator on the decode side.
package instruction_encoder_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned COUNT_W = 16;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  typedef struct packed {
    logic  valid;
    fmt_e  fmt;
  } fmt_dec_t;

  // Raw instruction fields as supplied by the program source
  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [INSTR_W-1:0] imm;
  } instr_fields_t;

  // Map an opcode onto its encoding format; valid=0 for unsupported opcodes
  function automatic fmt_dec_t decode_fmt(input logic [6:0] op);
    fmt_dec_t d;
    d.valid = 1'b1;
    d.fmt   = FMT_R;
    case (op)
      OP_LOAD, OP_IMM: d.fmt = FMT_I;
      OP_STORE:        d.fmt = FMT_S;
      OP_BRANCH:       d.fmt = FMT_B;
      OP_REG:          d.fmt = FMT_R;
      default:         d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instruction_encoder_loader_instr_field_packer.sv
// Combinational RV32I field packer: fields -> 32-bit instruction word.
// Ports:
//   fields_i  : opcode/register/funct/immediate bundle
//   word_o    : encoded instruction (0 for unsupported opcodes)
//   fmt_ok_o  : opcode is one of the supported formats
//   imm_ok_o  : immediate is representable in the selected format
module instr_field_packer
  import instruction_encoder_loader_pkg::*;
(
  input  instr_fields_t        fields_i,
  output logic [INSTR_W-1:0]   word_o,
  output logic                 fmt_ok_o,
  output logic                 imm_ok_o
);

  fmt_dec_t           dec;
  logic [INSTR_W-1:0] imm;
  logic               fits12;
  logic               fits13;

  assign dec = decode_fmt(fields_i.opcode);
  assign imm = fields_i.imm;

  // Signed range checks: all bits above the sign bit must replicate it
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);

  always_comb begin
    word_o   = '0;
    fmt_ok_o = dec.valid;
    imm_ok_o = 1'b0;
    if (dec.valid) begin
      unique case (dec.fmt)
        FMT_I: begin
          word_o   = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
          imm_ok_o = fits12;
        end
        FMT_S: begin
          word_o   = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0],
                      fields_i.opcode};
          imm_ok_o = fits12;
        end
        FMT_B: begin
          word_o   = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                      imm[4:1], imm[11], fields_i.opcode};
          imm_ok_o = fits13 && !imm[0];
        end
        FMT_R: begin
          word_o   = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3, fields_i.rd,
                      fields_i.opcode};
          imm_ok_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Program loader: encodes RV32I field bundles and streams them into imem at
// consecutive word addresses, one word per cycle, one cycle of latency.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, base_addr    : open a load session at base_addr (word aligned)
//   in_valid/in_ready   : field bundle handshake; in_last closes the session
//   in_opcode..in_imm   : instruction fields
//   mem_we/addr/wdata   : imem write port
//   busy, done, err     : session status (err sticky until next start)
//   word_count          : words written this session
module instruction_encoder_loader
  import instruction_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [INSTR_W-1:0]  in_imm,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [COUNT_W-1:0]  word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;

  instr_fields_t       fields;
  logic [INSTR_W-1:0]  enc_word;
  logic                fmt_ok;
  logic                imm_ok;
  logic                accept;
  logic                good;

  assign fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  instr_field_packer u_packer (
    .fields_i (fields),
    .word_o   (enc_word),
    .fmt_ok_o (fmt_ok),
    .imm_ok_o (imm_ok)
  );

  assign accept = in_valid && (state_q == ST_LOAD);
  assign good   = fmt_ok && imm_ok && (count_q != COUNT_W'(DEPTH_WORDS));

  // Next-state: session control, address/count advance, write staging
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = base_addr & ~ADDR_W'(3);
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Rejected bundles still complete the handshake and may close the session
          if (good) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc_word;
            addr_d  = addr_q + ADDR_W'(4);
            count_d = count_q + COUNT_W'(1);
          end else begin
            err_d   = 1'b1;
          end
          if (in_last) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD) || we_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign word_count = count_q;
  assign mem_we     = we_q;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: table of hand-encoded
// instructions plus sequences for session control, depth limit and reset.
module tb_instruction_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;

  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;

  logic        d2_in_ready, d2_mem_we, d2_busy, d2_done, d2_err;
  logic [31:0] d2_mem_addr, d2_mem_wdata;
  logic [15:0] d2_word_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_encoder_loader #(.ADDR_W(32), .DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  instruction_encoder_loader #(.ADDR_W(32), .DEPTH_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .busy(d2_busy), .done(d2_done), .err(d2_err), .word_count(d2_word_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        good;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  function automatic vec_t mkv(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input logic good, input logic [31:0] word);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.good = good; v.word = word;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic last);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    in_last   = last;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic begin_session(input logic [31:0] base);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
  endtask

  vec_t addi5;
  logic [31:0] exp_addr;
  logic [15:0] exp_cnt;
  logic        exp_err;

  initial begin
    tbl[0]  = mkv(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        1'b1, 32'h0020A423); // sw x2,8(x1)
    tbl[1]  = mkv(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3); // beq -4
    tbl[2]  = mkv(7'h03, 5'd5, 5'd0, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF02283); // lw x5,-1(x0)
    tbl[3]  = mkv(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h12345678, 1'b1, 32'h002081B3); // add x3,x1,x2
    tbl[4]  = mkv(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     1'b0, 32'h0);        // addi 2048
    tbl[5]  = mkv(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        1'b0, 32'h0);        // beq odd
    tbl[6]  = mkv(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        1'b0, 32'h0);        // bad opcode
    tbl[7]  = mkv(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b1, 32'h80000093); // addi -2048
    tbl[8]  = mkv(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     1'b1, 32'h7E000FE3); // beq +4094
    tbl[9]  = mkv(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 1'b1, 32'h80000063); // beq -4096
    tbl[10] = mkv(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     1'b0, 32'h0);        // beq 4096
    tbl[11] = mkv(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF, 1'b0, 32'h0);        // sw -2049
    tbl[12] = mkv(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     1'b1, 32'h7FF00093); // addi 2047
    addi5   = mkv(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        1'b1, 32'h00500093);

    rst = 1'b1; start = 1'b0; base_addr = '0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset word_count", 32'(word_count), 32'd0);

    // Single addi session
    begin_session(32'h100);
    chk("load in_ready", 32'(in_ready), 32'd1);
    chk("load busy", 32'(busy), 32'd1);
    drive(addi5, 1'b1);
    tick();
    idle_inputs();
    chk("addi mem_we", 32'(mem_we), 32'd1);
    chk("addi mem_addr", mem_addr, 32'h100);
    chk("addi wdata", mem_wdata, 32'h00500093);
    chk("addi done", 32'(done), 32'd1);
    chk("addi busy in write", 32'(busy), 32'd1);
    chk("addi in_ready", 32'(in_ready), 32'd0);
    chk("addi count", 32'(word_count), 32'd1);
    chk("addi err", 32'(err), 32'd0);
    tick();
    chk("after write mem_we", 32'(mem_we), 32'd0);
    chk("after write busy", 32'(busy), 32'd0);
    chk("after write done", 32'(done), 32'd1);

    // Table session, back-to-back; base low bits must be dropped.
    // start stays high mid-session with another base to show it is ignored.
    begin_session(32'h203);
    exp_addr = 32'h200; exp_cnt = '0; exp_err = 1'b0;
    for (int i = 0; i < NV; i++) begin
      start = (i != NV - 1); base_addr = 32'h900;
      drive(tbl[i], i == NV - 1);
      tick();
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tbl[i].good));
      if (tbl[i].good) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, exp_addr);
        chk($sformatf("v%0d wdata", i), mem_wdata, tbl[i].word);
        exp_addr = exp_addr + 32'd4;
        exp_cnt  = exp_cnt + 16'd1;
      end else begin
        exp_err = 1'b1;
      end
      chk($sformatf("v%0d err", i), 32'(err), 32'(exp_err));
      chk($sformatf("v%0d count", i), 32'(word_count), 32'(exp_cnt));
      chk($sformatf("v%0d done", i), 32'(done), 32'(i == NV - 1));
    end
    start = 1'b0;

    // in_valid while DONE: no effect
    drive(addi5, 1'b0);
    tick();
    chk("done valid mem_we", 32'(mem_we), 32'd0);
    chk("done valid count", 32'(word_count), 32'(exp_cnt));
    chk("done valid err", 32'(err), 32'd1);
    idle_inputs();

    // New session clears err and count
    begin_session(32'h0);
    chk("restart err", 32'(err), 32'd0);
    chk("restart count", 32'(word_count), 32'd0);
    chk("restart done", 32'(done), 32'd0);

    // Depth limit on the 2-word instance: third word rejected
    for (int i = 0; i < 3; i++) begin
      drive(addi5, i == 2);
      tick();
      chk($sformatf("depth w%0d mem_we", i), 32'(d2_mem_we), 32'(i < 2));
      if (i < 2) chk($sformatf("depth w%0d addr", i), d2_mem_addr, 32'(4 * i));
    end
    idle_inputs();
    chk("depth count", 32'(d2_word_count), 32'd2);
    chk("depth err", 32'(d2_err), 32'd1);
    chk("depth done", 32'(d2_done), 32'd1);
    chk("depth main count", 32'(word_count), 32'd3);

    // Reset the cycle after an accept with in_valid held
    begin_session(32'h400);
    drive(addi5, 1'b0);
    tick();
    chk("pre-rst mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst count", 32'(word_count), 32'd0);
    tick();
    chk("idle valid mem_we", 32'(mem_we), 32'd0);
    chk("idle valid in_ready", 32'(in_ready), 32'd0);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
